// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder.
// Holds the response FSM encoding, byte-lane width, the full-word mask
// constant and a helper that widens a byte mask to a bit mask.
package dmem_responder_pkg;

    localparam int BYTE_EN_W = 4;
    localparam logic [BYTE_EN_W-1:0] MASK_WORD = 4'b1111;

    typedef enum logic [1:0] {
        RESP_IDLE = 2'd0,
        RESP_WAIT = 2'd1,
        RESP_RESP = 2'd2
    } resp_state_e;

    // Widen a per-byte enable into a per-bit enable for a 32-bit word.
    function automatic logic [31:0] expand_mask(input logic [BYTE_EN_W-1:0] mask);
        logic [31:0] bits;
        bits = 32'd0;
        for (int b = 0; b < BYTE_EN_W; b++) begin
            bits[8*b +: 8] = {8{mask[b]}};
        end
        return bits;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the MEM-stage requester (master) and the
// data-memory responder (slave). Signal names carry the responder's view:
//   req_valid_i/req_ready_o  request handshake
//   req_we_i, req_addr_i, req_mask_i, req_wdata_i  request payload
//   resp_valid_o, resp_rdata_o, resp_err_o  one-cycle completion
interface dmem_responder_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_we_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [3:0]        req_mask_i;
    logic [31:0]       req_wdata_i;
    logic              resp_valid_o;
    logic [31:0]       resp_rdata_o;
    logic              resp_err_o;

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_mask_i, req_wdata_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_mask_i, req_wdata_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
    );
endinterface

// File: rtl/dmem_responder_bank.sv
// dmem_bank: byte-masked 32-bit storage array.
//   clk      clock
//   we       write strobe (caller guarantees an in-range address)
//   re       read strobe; the read register holds its value otherwise
//   addr     word address
//   mask     byte enables for writes
//   wdata    lane-aligned write data
//   rdata    registered read data
// The array has no reset so contents survive a responder reset.
module dmem_bank
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic                 re,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [BYTE_EN_W-1:0] mask,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata
);

    // Index only as wide as the array needs; callers gate strobes on range.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]      mem_r [DEPTH];
    logic [IDX_W-1:0] idx_s;

    assign idx_s = addr[IDX_W-1:0];

    // Byte-lane masked write.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BYTE_EN_W; b++) begin
                if (mask[b]) begin
                    mem_r[idx_s][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Registered read, held between read strobes.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem_r[idx_s];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: target-side responder for MEM-stage data requests.
//   clk    clock, rising edge
//   reset  synchronous, active-high
//   bus    dmem_responder_if.slave request/response bundle
// Stores commit and loads sample on the acceptance edge. With WAIT_CYCLES=0
// every request is answered in the following cycle; otherwise an
// IDLE/WAIT/RESP sequencer inserts WAIT_CYCLES cycles before the response.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);

    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic [3:0]      WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    resp_state_e state_r;
    logic [3:0]  cnt_r;
    logic        ready_r;
    logic        resp_valid_r;
    logic        err_r;
    logic        ld_ok_r;
    logic [31:0] rd_data_s;
    logic        accept_s;
    logic        in_range_s;
    logic        bank_we_s;
    logic        bank_re_s;

    // Extra top bit keeps the compare correct when DEPTH == 2**ADDR_W.
    assign in_range_s = ({1'b0, bus.req_addr_i} < DEPTH_EXT);
    assign accept_s   = bus.req_valid_i && ready_r && !reset;
    assign bank_we_s  = accept_s && bus.req_we_i && in_range_s;
    assign bank_re_s  = accept_s && !bus.req_we_i && in_range_s;

    dmem_bank #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_bank (
        .clk   (clk),
        .we    (bank_we_s),
        .re    (bank_re_s),
        .addr  (bus.req_addr_i),
        .mask  (bus.req_mask_i),
        .wdata (bus.req_wdata_i),
        .rdata (rd_data_s)
    );

    // Handshake / wait-state sequencer; response flags captured on acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= RESP_IDLE;
            cnt_r        <= 4'd0;
            ready_r      <= 1'b1;
            resp_valid_r <= 1'b0;
            err_r        <= 1'b0;
            ld_ok_r      <= 1'b0;
        end else begin
            case (state_r)
                RESP_IDLE: begin
                    if (accept_s) begin
                        err_r   <= !in_range_s;
                        ld_ok_r <= !bus.req_we_i && in_range_s;
                        if (WAIT_CYCLES == 0) begin
                            // Pipelined: stay ready, answer next cycle.
                            resp_valid_r <= 1'b1;
                        end else begin
                            state_r      <= RESP_WAIT;
                            cnt_r        <= WAIT_INIT;
                            ready_r      <= 1'b0;
                            resp_valid_r <= 1'b0;
                        end
                    end else begin
                        resp_valid_r <= 1'b0;
                    end
                end
                RESP_WAIT: begin
                    if (cnt_r == 4'd0) begin
                        state_r      <= RESP_RESP;
                        resp_valid_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                RESP_RESP: begin
                    state_r      <= RESP_IDLE;
                    resp_valid_r <= 1'b0;
                    ready_r      <= 1'b1;
                end
                default: begin
                    state_r      <= RESP_IDLE;
                    cnt_r        <= 4'd0;
                    ready_r      <= 1'b1;
                    resp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Data and error are forced to zero outside the response pulse.
    assign bus.req_ready_o  = ready_r;
    assign bus.resp_valid_o = resp_valid_r;
    assign bus.resp_err_o   = resp_valid_r && err_r;
    assign bus.resp_rdata_o = (resp_valid_r && ld_ok_r) ? rd_data_s : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    // u0: pipelined, u3: three wait states, u5: pipelined with DEPTH=512
    dmem_responder_if #(.ADDR_W(10)) if0 ();
    dmem_responder_if #(.ADDR_W(10)) if3 ();
    dmem_responder_if #(.ADDR_W(10)) if5 ();

    dmem_responder #(.ADDR_W(10), .DEPTH(1024), .WAIT_CYCLES(0)) u0 (.clk(clk), .reset(reset), .bus(if0));
    dmem_responder #(.ADDR_W(10), .DEPTH(1024), .WAIT_CYCLES(3)) u3 (.clk(clk), .reset(reset), .bus(if3));
    dmem_responder #(.ADDR_W(10), .DEPTH(512),  .WAIT_CYCLES(0)) u5 (.clk(clk), .reset(reset), .bus(if5));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req0(input logic v, input logic we, input logic [9:0] a, input logic [3:0] m, input logic [31:0] d);
        if0.req_valid_i = v; if0.req_we_i = we; if0.req_addr_i = a; if0.req_mask_i = m; if0.req_wdata_i = d;
    endtask

    task automatic req3(input logic v, input logic we, input logic [9:0] a, input logic [3:0] m, input logic [31:0] d);
        if3.req_valid_i = v; if3.req_we_i = we; if3.req_addr_i = a; if3.req_mask_i = m; if3.req_wdata_i = d;
    endtask

    task automatic req5(input logic v, input logic we, input logic [9:0] a, input logic [3:0] m, input logic [31:0] d);
        if5.req_valid_i = v; if5.req_we_i = we; if5.req_addr_i = a; if5.req_mask_i = m; if5.req_wdata_i = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        n_cmp++; if (if0.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready0 got %b want 1", if0.req_ready_o); end
        n_cmp++; if (if3.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready3 got %b want 1", if3.req_ready_o); end
        n_cmp++; if (if0.resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid0 got %b want 0", if0.resp_valid_o); end
        n_cmp++; if (if3.resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid3 got %b want 0", if3.resp_valid_o); end
        n_cmp++; if (if0.resp_rdata_o !== 32'd0) begin n_fail++; $display("FAIL rst_rdata0 got %h want 0", if0.resp_rdata_o); end
        n_cmp++; if (if3.resp_err_o !== 1'b0) begin n_fail++; $display("FAIL rst_err3 got %b want 0", if3.resp_err_o); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_store_load();
        req0(1'b1, 1'b1, 10'h004, 4'b1111, 32'hDEADBEEF);
        tick();
        n_cmp++; if (if0.resp_valid_o !== 1'b1) begin n_fail++; $display("FAIL sl_st_valid got %b want 1", if0.resp_valid_o); end
        n_cmp++; if (if0.resp_rdata_o !== 32'd0) begin n_fail++; $display("FAIL sl_st_rdata got %h want 0", if0.resp_rdata_o); end
        req0(1'b1, 1'b0, 10'h004, 4'b0000, 32'd0);
        tick();
        n_cmp++; if (if0.resp_valid_o !== 1'b1) begin n_fail++; $display("FAIL sl_ld_valid got %b want 1", if0.resp_valid_o); end
        n_cmp++; if (if0.resp_rdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sl_ld_rdata got %h want deadbeef", if0.resp_rdata_o); end
        n_cmp++; if (if0.resp_err_o !== 1'b0) begin n_fail++; $display("FAIL sl_ld_err got %b want 0", if0.resp_err_o); end
        req0(1'b0, 1'b0, 10'h000, 4'b0000, 32'd0);
        tick();
        n_cmp++; if (if0.resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL sl_idle_valid got %b want 0", if0.resp_valid_o); end
        n_cmp++; if (if0.resp_rdata_o !== 32'd0) begin n_fail++; $display("FAIL sl_idle_rdata got %h want 0", if0.resp_rdata_o); end
    endtask

    task automatic test_masked();
        req0(1'b1, 1'b1, 10'h008, 4'b1111, 32'h11223344); tick();
        req0(1'b1, 1'b1, 10'h008, 4'b0101, 32'hAABBCCDD); tick();
        req0(1'b1, 1'b0, 10'h008, 4'b0000, 32'd0); tick();
        n_cmp++; if (if0.resp_rdata_o !== 32'h11BB33DD) begin n_fail++; $display("FAIL mask_0101 got %h want 11bb33dd", if0.resp_rdata_o); end
        req0(1'b1, 1'b1, 10'h008, 4'b0000, 32'hFFFFFFFF); tick();
        n_cmp++; if (if0.resp_valid_o !== 1'b1) begin n_fail++; $display("FAIL mask_0000_valid got %b want 1", if0.resp_valid_o); end
        req0(1'b1, 1'b0, 10'h008, 4'b0000, 32'd0); tick();
        n_cmp++; if (if0.resp_rdata_o !== 32'h11BB33DD) begin n_fail++; $display("FAIL mask_0000_data got %h want 11bb33dd", if0.resp_rdata_o); end
        req0(1'b0, 1'b0, 10'h000, 4'b0000, 32'd0); tick();
    endtask

    task automatic test_wait_states();
        n_cmp++; if (if3.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL ws_ready_pre got %b want 1", if3.req_ready_o); end
        req3(1'b1, 1'b1, 10'h010, 4'b1111, 32'hCAFEF00D);
        tick();
        // Next request is presented and held throughout the wait period.
        req3(1'b1, 1'b0, 10'h010, 4'b0000, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            n_cmp++; if (if3.req_ready_o !== 1'b0) begin n_fail++; $display("FAIL ws_st_ready k=%0d got %b want 0", k, if3.req_ready_o); end
            n_cmp++; if (if3.resp_valid_o !== (k == 4)) begin n_fail++; $display("FAIL ws_st_valid k=%0d got %b want %b", k, if3.resp_valid_o, (k == 4)); end
            if (k == 4) begin
                n_cmp++; if (if3.resp_rdata_o !== 32'd0) begin n_fail++; $display("FAIL ws_st_rdata got %h want 0", if3.resp_rdata_o); end
            end
            tick();
        end
        n_cmp++; if (if3.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL ws_ready_back got %b want 1", if3.req_ready_o); end
        n_cmp++; if (if3.resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL ws_valid_back got %b want 0", if3.resp_valid_o); end
        tick();
        req3(1'b0, 1'b0, 10'h000, 4'b0000, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            n_cmp++; if (if3.resp_valid_o !== (k == 4)) begin n_fail++; $display("FAIL ws_ld_valid k=%0d got %b want %b", k, if3.resp_valid_o, (k == 4)); end
            if (k == 4) begin
                n_cmp++; if (if3.resp_rdata_o !== 32'hCAFEF00D) begin n_fail++; $display("FAIL ws_ld_rdata got %h want cafef00d", if3.resp_rdata_o); end
            end
            tick();
        end
        n_cmp++; if (if3.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL ws_ready_end got %b want 1", if3.req_ready_o); end
    endtask

    task automatic test_range();
        req5(1'b1, 1'b1, 10'h1FF, 4'b1111, 32'h0BADCAFE); tick();
        n_cmp++; if (if5.resp_err_o !== 1'b0) begin n_fail++; $display("FAIL rng_st_1ff_err got %b want 0", if5.resp_err_o); end
        req5(1'b1, 1'b0, 10'h200, 4'b0000, 32'd0); tick();
        n_cmp++; if (if5.resp_valid_o !== 1'b1) begin n_fail++; $display("FAIL rng_ld_200_valid got %b want 1", if5.resp_valid_o); end
        n_cmp++; if (if5.resp_err_o !== 1'b1) begin n_fail++; $display("FAIL rng_ld_200_err got %b want 1", if5.resp_err_o); end
        n_cmp++; if (if5.resp_rdata_o !== 32'd0) begin n_fail++; $display("FAIL rng_ld_200_rdata got %h want 0", if5.resp_rdata_o); end
        req5(1'b1, 1'b1, 10'h3FF, 4'b1111, 32'hFFFFFFFF); tick();
        n_cmp++; if (if5.resp_err_o !== 1'b1) begin n_fail++; $display("FAIL rng_st_3ff_err got %b want 1", if5.resp_err_o); end
        req5(1'b1, 1'b0, 10'h1FF, 4'b0000, 32'd0); tick();
        n_cmp++; if (if5.resp_rdata_o !== 32'h0BADCAFE) begin n_fail++; $display("FAIL rng_ld_1ff got %h want 0badcafe", if5.resp_rdata_o); end
        n_cmp++; if (if5.resp_err_o !== 1'b0) begin n_fail++; $display("FAIL rng_ld_1ff_err got %b want 0", if5.resp_err_o); end
        req5(1'b0, 1'b0, 10'h000, 4'b0000, 32'd0); tick();
        n_cmp++; if (if5.resp_err_o !== 1'b0) begin n_fail++; $display("FAIL rng_idle_err got %b want 0", if5.resp_err_o); end
    endtask

    task automatic test_reset_pending();
        logic found;
        req3(1'b1, 1'b1, 10'h020, 4'b1111, 32'h5A5A1234);
        tick();
        req3(1'b0, 1'b0, 10'h000, 4'b0000, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (if3.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL rp_ready got %b want 1", if3.req_ready_o); end
        for (int k = 0; k < 6; k++) begin
            n_cmp++; if (if3.resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL rp_no_resp k=%0d got %b want 0", k, if3.resp_valid_o); end
            tick();
        end
        req3(1'b1, 1'b0, 10'h020, 4'b0000, 32'd0);
        tick();
        req3(1'b0, 1'b0, 10'h000, 4'b0000, 32'd0);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (if3.resp_valid_o === 1'b1) begin
                found = 1'b1;
                n_cmp++; if (if3.resp_rdata_o !== 32'h5A5A1234) begin n_fail++; $display("FAIL rp_ld_rdata got %h want 5a5a1234", if3.resp_rdata_o); end
            end
            tick();
        end
        n_cmp++; if (found !== 1'b1) begin n_fail++; $display("FAIL rp_ld_timeout got %b want 1", found); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [9:0]  a;
        for (int i = 0; i < 10; i++) begin
            a = 10'h040 + 10'(i / 2);
            d = 32'hC0DE0000 | 32'(i / 2);
            req0(1'b1, (i % 2) == 0, a, 4'b1111, d);
            tick();
            n_cmp++; if (if0.resp_valid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_valid i=%0d got %b want 1", i, if0.resp_valid_o); end
            if ((i % 2) == 1) begin
                n_cmp++; if (if0.resp_rdata_o !== d) begin n_fail++; $display("FAIL b2b_rdata i=%0d got %h want %h", i, if0.resp_rdata_o, d); end
            end
        end
        req0(1'b0, 1'b0, 10'h000, 4'b0000, 32'd0);
        tick();
        n_cmp++; if (if0.resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_end_valid got %b want 0", if0.resp_valid_o); end
    endtask

    initial begin
        req0(1'b0, 1'b0, 10'h000, 4'b0000, 32'd0);
        req3(1'b0, 1'b0, 10'h000, 4'b0000, 32'd0);
        req5(1'b0, 1'b0, 10'h000, 4'b0000, 32'd0);
        test_reset();
        test_store_load();
        test_masked();
        test_wait_states();
        test_range();
        test_reset_pending();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
